button_conditioner: RTL

Conditions the raw Basys 3 push-buttons before they reach the LED machine's control path. Each channel is synchronised, debounced, and turned into a clean level plus single-cycle press and release pulses. The block sits directly upstream of ledMachine's btnU (changeMode) and btnD (send) inputs. Without it, one mechanical press can register as several mode changes or sends.

---
 rtl/button_conditioner_pkg.sv | 24 ++
 rtl/button_conditioner_if.sv | 24 ++
 rtl/button_conditioner_debounce_channel.sv | 148 ++++++++++++++
 rtl/button_conditioner.sv | 37 +++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared state encoding and 100 MHz board timing defaults
// for the push-button conditioner.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_NUM_BTN         = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 20000000;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button levels in, conditioned level and strobes out.
// The board/test side is the master, the conditioner the slave.
interface button_conditioner_if #(
    parameter int unsigned NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btnRaw;
    logic [NUM_BTN-1:0] btnLevel;
    logic [NUM_BTN-1:0] btnPress;
    logic [NUM_BTN-1:0] btnRelease;

    modport master (
        output btnRaw,
        input  btnLevel,
        input  btnPress,
        input  btnRelease
    );

    modport slave (
        input  btnRaw,
        output btnLevel,
        output btnPress,
        output btnRelease
    );
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button: 2-flop synchroniser, debounce FSM and counter.
// BUTTON_AUTOREPEAT_EN adds repeated press strobes while held.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync2_q;
    btn_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic rel_q, rel_d;
    logic accept_press;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        accept_press = 1'b0;
        rel_d        = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_PEND: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = HELD;
                    cnt_d        = '0;
                    level_d      = 1'b1;
                    accept_press = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_PEND: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW =
        $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic rpt_q, rpt_d;
    logic rep_hit;

    // Count only while staying in HELD; any other cycle restarts the delay.
    always_comb begin
        rep_d   = rep_q;
        rpt_d   = rpt_q;
        rep_hit = 1'b0;
        if (state_q == HELD && sync2_q) begin
            if ((!rpt_q && rep_q == DLY_LAST) ||
                (rpt_q && rep_q == PER_LAST)) begin
                rep_hit = 1'b1;
                rep_d   = '0;
                rpt_d   = 1'b1;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end else begin
            rep_d = '0;
            rpt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_q <= '0;
            rpt_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
            rpt_q <= rpt_d;
        end
    end

    assign press_d = accept_press | rep_hit;
`else
    assign press_d = accept_press;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;
endmodule

// File: rtl/button_conditioner.sv
// Per-button debounce in front of ledMachine's control inputs.
// Optional auto-repeat: define BUTTON_AUTOREPEAT_EN.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input logic clk,
    input logic reset,
    button_conditioner_if.slave btn
);
    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] rel_w;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (btn.btnRaw[i]),
            .level(level_w[i]),
            .press(press_w[i]),
            .rel  (rel_w[i])
        );
    end

    assign btn.btnLevel   = level_w;
    assign btn.btnPress   = press_w;
    assign btn.btnRelease = rel_w;
endmodule
